// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: access-type encodings,
// FSM states, bus widths and small type-decode helpers.
package lsu_mem_ctrl_pkg;

    localparam int XLEN    = 32;
    localparam int WADDR_W = 30;
    localparam int BE_W    = 4;

    // Same 3-bit encoding the register-file write extension uses.
    typedef enum logic [2:0] {
        RT_WORD   = 3'b000,
        RT_BYTE_S = 3'b001,
        RT_BYTE_U = 3'b010,
        RT_HALF_S = 3'b011,
        RT_HALF_U = 3'b100
    } req_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_e;

    // Codes 101-111 fall through to word.
    function automatic acc_size_e type_size(input logic [2:0] rtype);
        case (rtype)
            RT_BYTE_S, RT_BYTE_U: return SZ_BYTE;
            RT_HALF_S, RT_HALF_U: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic type_signed(input logic [2:0] rtype);
        return (rtype == RT_BYTE_S) || (rtype == RT_HALF_S);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_fmt.sv
// Byte-lane formatter: byte enables, store-data replication, load-data
// extraction and sign/zero extension, plus alignment check. Pure logic.
module lsu_lane_fmt
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]      req_type,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] store_lanes,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    acc_size_e   size;
    logic        sgn;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Decode access size and build lane enables, store lanes and load result.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        be          = '0;
        store_lanes = '0;
        load_data   = '0;
        misaligned  = 1'b0;
        size        = type_size(req_type);
        sgn         = type_signed(req_type);
        byte_sel    = load_word[8*addr_lo +: 8];
        half_sel    = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        case (size)
            SZ_BYTE: begin
                be          = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = {{24{sgn & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = {{16{sgn & half_sel[15]}}, half_sel};
                misaligned  = addr_lo[0];
            end
            default: begin
                be          = 4'b1111;
                store_lanes = store_data;
                load_data   = load_word;
                misaligned  = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one request, runs a req/ack handshake to a
// word-wide memory with byte enables, and returns an extended load result.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [2:0]         req_type,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    rdata,
    output logic               err_misalign,
    output logic               err_timeout,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]    mem_be,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic               mem_ack
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic             we_q;
    logic [2:0]       type_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rdata_q;
    logic             mis_q;
    logic             to_q;

    logic             accept;
    logic             ack_take;
    logic             timeout_hit;

    logic [2:0]       fmt_type;
    logic [1:0]       fmt_addr_lo;
    logic [BE_W-1:0]  fmt_be;
    logic [XLEN-1:0]  fmt_store;
    logic [XLEN-1:0]  fmt_load;
    logic             fmt_mis;

    // In IDLE the formatter checks the incoming request; afterwards it
    // works from the registered copy so memory outputs stay stable.
    assign fmt_type    = (state_q == ST_IDLE) ? req_type      : type_q;
    assign fmt_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];

    lsu_lane_fmt u_lane_fmt (
        .req_type    (fmt_type),
        .addr_lo     (fmt_addr_lo),
        .store_data  (wdata_q),
        .load_word   (mem_rdata),
        .be          (fmt_be),
        .store_lanes (fmt_store),
        .load_data   (fmt_load),
        .misaligned  (fmt_mis)
    );

    // Next-state logic; an ack in the last allowed cycle beats the timeout.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        ack_take    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = fmt_mis ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    ack_take = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Request capture, wait counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            type_q  <= req_type;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= fmt_mis;
            to_q    <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            if (ack_take)         rdata_q <= we_q ? '0 : fmt_load;
            else if (timeout_hit) to_q    <= 1'b1;
            else                  cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Memory side is driven only while a request is outstanding.
    assign mem_req   = (state_q == ST_ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q[31:2] : '0;
    assign mem_be    = mem_req ? fmt_be       : '0;
    assign mem_wdata = mem_req ? fmt_store    : '0;

    // Response side is visible only during the done pulse.
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_RESP);
    assign rdata        = done ? rdata_q : '0;
    assign err_misalign = done & mis_q;
    assign err_timeout  = done & to_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vectors plus random
// transactions compared every cycle against a cycle-schedule model.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        busy, done, err_misalign, err_timeout;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_on = 1'b0;

    // Expected transaction, published by the driver.
    bit          exp_active = 1'b0;
    int          exp_e, exp_tdone, exp_rst;
    bit          exp_mis, exp_to, exp_we, exp_lit;
    logic [2:0]  exp_t;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [31:0] exp_lit_rdata, exp_lit_wdata;
    logic [3:0]  exp_lit_be;

    lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata),
        .err_misalign(err_misalign), .err_timeout(err_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 1;
        if (t == 3'd3 || t == 3'd4) return 2;
        return 4;
    endfunction

    function automatic bit m_signed(input logic [2:0] t);
        return (t == 3'd1) || (t == 3'd3);
    endfunction

    function automatic bit m_mis(input logic [2:0] t, input logic [31:0] a);
        return (a % m_size(t)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        logic [7:0] m;
        m = ((8'd1 << m_size(t)) - 8'd1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_steer(input logic [2:0] t, input logic [31:0] d);
        case (m_size(t))
            1:       return {24'd0, d[7:0]}  * 32'h0101_0101;
            2:       return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
        longint v, span;
        span = longint'(1) << (8 * m_size(t));
        v = longint'(w >> (8 * a[1:0])) % span;
        if (m_signed(t) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- per-cycle compare ----------------
    int c;
    bit in_win, e_done, e_req;
    // Compare DUT outputs with the model on the falling edge of every cycle.
    always @(negedge clk) begin
        if (cmp_on) begin
            c      = cyc;
            in_win = exp_active && c >= exp_e && c <= exp_tdone && c < exp_rst;
            e_done = in_win && c == exp_tdone;
            e_req  = in_win && !exp_mis && c < exp_tdone;
            check("busy",    32'(busy),    32'(in_win));
            check("done",    32'(done),    32'(e_done));
            check("mem_req", 32'(mem_req), 32'(e_req));
            if (e_req) begin
                check("mem_we",   32'(mem_we),   32'(exp_we));
                check("mem_addr", 32'(mem_addr), {2'b00, exp_addr[31:2]});
                check("mem_be",   32'(mem_be),   32'(m_be(exp_t, exp_addr)));
                if (exp_we) check("mem_wdata", mem_wdata, m_steer(exp_t, exp_wdata));
                if (exp_lit) begin
                    check("lit_be", 32'(mem_be), 32'(exp_lit_be));
                    if (exp_we) check("lit_wdata", mem_wdata, exp_lit_wdata);
                end
            end
            if (e_done) begin
                check("rdata",        rdata,              exp_rdata);
                check("err_misalign", 32'(err_misalign),  32'(exp_mis));
                check("err_timeout",  32'(err_timeout),   32'(exp_to));
                if (exp_lit) check("lit_rdata", rdata, exp_lit_rdata);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            next_cycle();
        end
    endtask

    // w < 0 means memory never acks; rst_off >= 0 asserts rst in cycle e+rst_off.
    task automatic run_txn(input bit we, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] mword,
                           input int w, input int rst_off, input bit lit,
                           input logic [31:0] lit_rd, input logic [3:0] lit_be,
                           input logic [31:0] lit_wd);
        int e, tdone;
        bit mis, to;
        mis   = m_mis(t, a);
        to    = !mis && (w < 0);
        e     = cyc + 1;
        tdone = mis ? e : (to ? e + TO : e + 1 + w);
        exp_e = e; exp_tdone = tdone;
        exp_rst = (rst_off >= 0) ? e + rst_off + 1 : 32'h7fff_ffff;
        exp_mis = mis; exp_to = to; exp_we = we; exp_t = t;
        exp_addr = a; exp_wdata = wd;
        exp_rdata = (mis || to || we) ? 32'd0 : m_load(t, a, mword);
        exp_lit = lit; exp_lit_rdata = lit_rd; exp_lit_be = lit_be; exp_lit_wdata = lit_wd;
        exp_active = 1'b1;
        req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
        mem_ack   = ($urandom_range(0, 1) == 1);
        mem_rdata = $urandom;
        next_cycle();
        for (int k = e; k <= tdone && k < exp_rst; k++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_we    = ($urandom_range(0, 1) == 1);
            req_type  = 3'($urandom_range(0, 7));
            req_addr  = $urandom;
            req_wdata = $urandom;
            mem_ack   = (!mis && !to && k == e + w) || (k == tdone && $urandom_range(0, 1) == 1);
            mem_rdata = (!mis && !to && k == e + w) ? mword : $urandom;
            rst       = (rst_off >= 0 && k == e + rst_off);
            next_cycle();
        end
        rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        bit          we;
        logic [2:0]  t;
        logic [31:0] a;
        int          w;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_done",      32'(done),         32'd0);
        check("rst_rdata",     rdata,             32'd0);
        check("rst_err_mis",   32'(err_misalign), 32'd0);
        check("rst_err_to",    32'(err_timeout),  32'd0);
        check("rst_mem_req",   32'(mem_req),      32'd0);
        check("rst_mem_we",    32'(mem_we),       32'd0);
        check("rst_mem_addr",  32'(mem_addr),     32'd0);
        check("rst_mem_be",    32'(mem_be),       32'd0);
        check("rst_mem_wdata", mem_wdata,         32'd0);
        next_cycle();
        cmp_on = 1'b1;

        // Directed vectors with hand-computed results.
        run_txn(0, 3'd0, 32'h100, 0, 32'hDEADBEEF, 0, -1, 1, 32'hDEADBEEF, 4'b1111, 0);
        run_txn(0, 3'd1, 32'h103, 0, 32'h80FF0102, 1, -1, 1, 32'hFFFFFF80, 4'b1000, 0);
        run_txn(0, 3'd2, 32'h103, 0, 32'h80FF0102, 0, -1, 1, 32'h00000080, 4'b1000, 0);
        run_txn(0, 3'd3, 32'h102, 0, 32'h7ABC1234, 0, -1, 1, 32'h00007ABC, 4'b1100, 0);
        run_txn(0, 3'd3, 32'h100, 0, 32'h7ABC1234, 2, -1, 1, 32'h00001234, 4'b0011, 0);
        run_txn(0, 3'd3, 32'h100, 0, 32'h0000F000, 0, -1, 1, 32'hFFFFF000, 4'b0011, 0);
        idle_cycles(1);
        run_txn(1, 3'd1, 32'h201, 32'h000000A5, 0, 3, -1, 1, 32'h0, 4'b0010, 32'hA5A5A5A5);
        run_txn(0, 3'd3, 32'h101, 0, 0, 0, -1, 1, 32'h0, 4'b0000, 0);
        run_txn(0, 3'd0, 32'h104, 0, 32'h11111111, -1, -1, 1, 32'h0, 4'b1111, 0);

        // Reset while in ACCESS, then a fresh request completes normally.
        run_txn(0, 3'd0, 32'h300, 0, 0, -1, 1, 0, 0, 0, 0);
        idle_cycles(2);
        run_txn(0, 3'd0, 32'h304, 0, 32'h12345678, 1, -1, 1, 32'h12345678, 4'b1111, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 1) == 1);
            t  = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 9) < 7) a = a - (a % m_size(t));
            w  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1));
            run_txn(we, t, a, $urandom, $urandom, w, -1, 0, 0, 0, 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        idle_cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        repeat (50000) @(posedge clk);
        errors++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
